arm_playback_sequencer: RTL and testbench
=========================================

# arm_playback_sequencer

Autonomous playback controller for the robotic-arm position memory. It walks a programmed address range, reads each 4-byte servo record (base, altura, angulo, garra) from the synchronous position RAM, and streams the four bytes through the shared UART transmitter. It holds each pose for a dwell time, then optionally loops. It sits between the position RAM read port and the UART TX request interface, beside the command FSM, and turns single-shot reads into timed trajectory playback.

## Interface
- clk_freq, 25_000_000 — input clock frequency in Hz (documentation/derivation only).
- DWELL_CYCLES, clk_freq/2 — clocks to hold each pose after its 4th byte completes (default 500 ms); must be ≥1.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins playback; ignored unless IDLE.
- stop  in  1  one-cycle pulse that aborts playback.
- loop_en  in  1  when 1, restart at first_addr after last_addr; sampled when each pass ends.
- first_addr  in  8  start address; sampled on an accepted start.
- last_addr  in  8  end address; sampled on an accepted start.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  8  RAM read address.
- mem_rd_data  in  32  RAM data, valid the cycle after mem_rd_en. [7:0] base, [15:8] altura, [23:16] angulo, [31:24] garra.
- tx_dv  out  1  one-cycle UART send request.
- tx_byte  out  8  byte to send, valid while tx_dv=1.
- tx_active  in  1  UART transmitter busy.
- busy  out  1  high in every state except IDLE (drives the reproduction LED, active-high here).
- cur_addr  out  8  address of the pose being played.
- done  out  1  one-cycle pulse when a non-looping pass completes.

## Operation
- States: IDLE, READ, LATCH, SEND, TX_WAIT, DWELL.
- IDLE: on start with no stop in the same cycle, register first_addr and last_addr, set cur_addr=first_addr and byte index k=0, then go to READ.
- READ: hold mem_rd_en=1 and mem_rd_addr=cur_addr for exactly 1 cycle, then go to LATCH.
- LATCH: capture mem_rd_data into a 32-bit pose register, then go to SEND.
- SEND: hold tx_dv=1 for exactly 1 cycle with tx_byte=pose[8k+7:8k], then go to TX_WAIT.
- TX_WAIT: ignore tx_active in the first cycle after SEND, because the UART raises it with one cycle of latency. After that, leave when tx_active=0.
  - If k<3: increment k, go to SEND.
  - If k=3: clear k, load the dwell counter with DWELL_CYCLES-1, go to DWELL.
- DWELL: decrement the counter. When it reaches 0:
  - If cur_addr≠last_addr: cur_addr increments mod 256 and the block goes to READ.
  - If cur_addr=last_addr and loop_en=1: cur_addr←first_addr, go to READ.
  - Otherwise: pulse done for 1 cycle and go to IDLE.
- Address range wraps: first_addr>last_addr plays first..255, 0..last_addr. first_addr=last_addr plays a single pose.
- The RAM is read again for every pose on every pass, so writes made between passes are picked up.
- stop:
  - In READ, LATCH, SEND or DWELL: go to IDLE on the next edge. This includes a SEND cycle in which tx_dv has already been issued; the UART still completes that byte.
  - In TX_WAIT: finish waiting for the current byte, then go to IDLE instead of continuing.
  - stop is latched as a pending flag until IDLE is reached.
  - Never produces done.
- start while busy: ignored. start and stop in the same IDLE cycle: stay in IDLE.
- Outputs are decoded from state and registers, with no combinational path from input to output.

## Timing
- Reset values: state=IDLE, mem_rd_en=0, mem_rd_addr=0, tx_dv=0, tx_byte=0, busy=0, cur_addr=0, done=0, k=0, stop flag cleared.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Any byte in flight in the UART is not this block's concern.
- Accepted start at edge t: busy=1 and READ from t+1, LATCH at t+2, first tx_dv at t+3.
- Per pose: 1 READ cycle + 1 LATCH cycle + 4×(1 SEND cycle + TX_WAIT cycles) + DWELL_CYCLES.
- From the cycle tx_active falls to the next tx_dv: 1 cycle (TX_WAIT exit → SEND).
- done is coincident with the first IDLE-bound transition. busy=0 on the cycle after done.
- tx_dv is never asserted while tx_active=1 except on the first SEND of a pose, which always follows DWELL or IDLE.

## Test plan
- Single pose: RAM[5]=0x44332211, first=last=5, loop_en=0, DWELL_CYCLES=4, UART model busy 10 cycles → tx bytes 0x11,0x22,0x33,0x44 in order; exactly one mem_rd_en with addr 5; done pulses once; busy falls the cycle after done.
- Range with wrap: first=254, last=1 → mem_rd_addr sequence 254, 255, 0, 1; 16 bytes sent; a single done.
- Loop: first=2, last=3, loop_en=1 → addresses 2, 3, 2, 3…. Drop loop_en during the second visit to address 3 → done after that pose, no further reads.
- Stop in TX_WAIT during byte k=1 → that byte completes; no further tx_dv or mem_rd_en; IDLE once tx_active falls; done stays 0.
- Start ignored while busy, and start+stop in the same IDLE cycle → no change to cur_addr or sequence; remains IDLE respectively.
- Async reset asserted in DWELL → all outputs at reset values immediately; a fresh start afterwards plays from the new first_addr.

Source files
------------

// File: rtl/arm_playback_sequencer.sv
// Trajectory playback controller: reads 4-byte servo poses from the position
// RAM over an address range, streams each byte through the shared UART TX,
// holds every pose for a dwell time and optionally loops over the range.
module arm_playback_sequencer #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int DWELL_CYCLES = CLK_FREQ / 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [7:0]  first_addr,
    input  logic [7:0]  last_addr,
    output logic        mem_rd_en,
    output logic [7:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    output logic        busy,
    output logic [7:0]  cur_addr,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, TX_WAIT, DWELL} state_t;

    localparam int             CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t           state, state_n;
    logic [1:0]       k, k_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       first_q, first_n;
    logic [7:0]       last_q, last_n;
    logic [7:0]       cur_q, cur_n;
    logic             stop_pend, stop_pend_n;
    logic             wait_first, wait_first_n;
    logic             loop_q;
    logic [31:0]      pose;
    logic             pass_end;

    // The pass is over when the last pose's dwell expires; loop_en is taken
    // from a register so that done stays free of any input-to-output path.
    assign pass_end = (state == DWELL) && (cnt == '0) && (cur_q == last_q);

    // State and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            k          <= 2'd0;
            cnt        <= '0;
            first_q    <= 8'd0;
            last_q     <= 8'd0;
            cur_q      <= 8'd0;
            stop_pend  <= 1'b0;
            wait_first <= 1'b0;
            loop_q     <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            cnt        <= cnt_n;
            first_q    <= first_n;
            last_q     <= last_n;
            cur_q      <= cur_n;
            stop_pend  <= stop_pend_n;
            wait_first <= wait_first_n;
            loop_q     <= loop_en;
        end
    end

    // Pose register: captures the RAM word in the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            pose <= mem_rd_data;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_n      = state;
        k_n          = k;
        cnt_n        = cnt;
        first_n      = first_q;
        last_n       = last_q;
        cur_n        = cur_q;
        stop_pend_n  = stop_pend | stop;
        wait_first_n = 1'b0;
        case (state)
            IDLE: begin
                stop_pend_n = 1'b0;
                if (start && !stop) begin
                    first_n = first_addr;
                    last_n  = last_addr;
                    cur_n   = first_addr;
                    k_n     = 2'd0;
                    state_n = READ;
                end
            end
            READ: begin
                state_n = stop ? IDLE : LATCH;
            end
            LATCH: begin
                state_n = stop ? IDLE : SEND;
            end
            SEND: begin
                if (stop) begin
                    state_n = IDLE;
                end else begin
                    state_n      = TX_WAIT;
                    wait_first_n = 1'b1;
                end
            end
            TX_WAIT: begin
                // The UART raises tx_active one cycle late, so the first
                // cycle here is skipped before trusting it.
                if (!wait_first && !tx_active) begin
                    if (stop_pend || stop) begin
                        state_n = IDLE;
                    end else if (k != 2'd3) begin
                        k_n     = k + 2'd1;
                        state_n = SEND;
                    end else begin
                        k_n     = 2'd0;
                        cnt_n   = DWELL_LOAD;
                        state_n = DWELL;
                    end
                end
            end
            DWELL: begin
                if (pass_end && !loop_q) begin
                    state_n = IDLE;
                end else if (stop) begin
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (cur_q != last_q) begin
                    cur_n   = cur_q + 8'd1;
                    state_n = READ;
                end else begin
                    cur_n   = first_q;
                    state_n = READ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from state and registers.
    always_comb begin
        mem_rd_en   = (state == READ);
        mem_rd_addr = (state == READ) ? cur_q : 8'd0;
        tx_dv       = (state == SEND);
        tx_byte     = (state == SEND) ? pose[{k, 3'b000} +: 8] : 8'd0;
        busy        = (state != IDLE);
        cur_addr    = cur_q;
        done        = pass_end && !loop_q;
    end

endmodule

// File: tb/tb_arm_playback_sequencer.sv
// Scoreboard bench for arm_playback_sequencer with RAM and UART models.
module tb_arm_playback_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [7:0]  first_addr = 8'd0;
    logic [7:0]  last_addr = 8'd0;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [31:0] mem_rd_data = 32'd0;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        busy;
    logic [7:0]  cur_addr;
    logic        done;

    arm_playback_sequencer #(.CLK_FREQ(25_000_000), .DWELL_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .loop_en(loop_en), .first_addr(first_addr), .last_addr(last_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active),
        .busy(busy), .cur_addr(cur_addr), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int tx_cnt = 0;

    logic [31:0] ram [256];

    // Synchronous RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    // UART: raises tx_active one cycle after a request, busy for N cycles.
    logic uart_pend = 1'b0;
    int   uart_cnt = 0;
    int   fixed_busy = 0;
    always @(posedge clk) begin
        uart_pend <= tx_dv;
        if (uart_pend) uart_cnt <= (fixed_busy != 0) ? fixed_busy : int'($urandom_range(1, 6));
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_active = (uart_cnt > 0);

    typedef struct {
        int         kind;   // 0 read address, 1 tx byte, 2 done
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Reference model: a run visits first..last (wrapping mod 256) once per
    // pass, one read and four bytes per pose, then a single done.
    task automatic expect_run(input logic [7:0] f, input logic [7:0] l, input int passes, input bit with_done);
        logic [7:0] a;
        for (int p = 0; p < passes; p++) begin
            a = f;
            for (int guard = 0; guard < 256; guard++) begin
                push_ev(0, a);
                for (int b = 0; b < 4; b++) push_ev(1, ram[a][8*b +: 8]);
                if (a == l) break;
                a = a + 8'd1;
            end
        end
        if (with_done) push_ev(2, 8'd0);
    endtask

    task automatic check_ev(input int kind, input logic [7:0] val, input string name);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event kind %0d value %0h, expected none", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                fails++;
                $display("FAIL %s: got kind %0d value %0h expected kind %0d value %0h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rd_en) begin
                check_ev(0, mem_rd_addr, "rd_addr");
                chk("cur_addr_at_read", {24'd0, cur_addr}, {24'd0, mem_rd_addr});
                rd_cnt++;
            end
            if (tx_dv) begin
                check_ev(1, tx_byte, "tx_byte");
                tx_cnt++;
            end
            if (done) begin
                check_ev(2, 8'd0, "done");
                chk("busy_with_done", {31'd0, busy}, 32'd1);
            end
            if (done_prev) chk("busy_after_done", {31'd0, busy}, 32'd0);
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] f, input logic [7:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            cyc();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        repeat (3) cyc();
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_count(input string name, input int target, input bit use_rd);
        int n = 0;
        while (((use_rd ? rd_cnt : tx_cnt) < target) && n < 3000) begin
            cyc();
            n++;
        end
        chk(name, (use_rd ? rd_cnt : tx_cnt) >= target, 32'd1);
    endtask

    task automatic wait_active(input string name, input logic lvl);
        int n = 0;
        while (tx_active !== lvl && n < 100) begin
            cyc();
            n++;
        end
        chk(name, {31'd0, tx_active}, {31'd0, lvl});
    endtask

    initial begin
        logic [7:0] f, l, saved;
        int base;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;

        // Reset state.
        repeat (2) cyc();
        chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_mem_rd_addr", {24'd0, mem_rd_addr}, 32'd0);
        chk("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cur_addr", {24'd0, cur_addr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        repeat (2) cyc();

        // Single pose with a fixed 10-cycle UART.
        fixed_busy = 10;
        ram[5] = 32'h44332211;
        expect_run(8'd5, 8'd5, 1, 1'b1);
        pulse_start(8'd5, 8'd5);
        chk("single_busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle("single_idle");
        fixed_busy = 0;

        // Range wrapping through 255 -> 0.
        expect_run(8'd254, 8'd1, 1, 1'b1);
        pulse_start(8'd254, 8'd1);
        wait_idle("wrap_idle");

        // Random short ranges with random contents and UART timing.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) ram[i] = $urandom;
            f = 8'($urandom);
            l = f + 8'($urandom_range(0, 3));
            expect_run(f, l, 1, 1'b1);
            pulse_start(f, l);
            wait_idle("rand_idle");
        end

        // Loop 2..3, drop loop_en on the second visit to address 3.
        loop_en = 1'b1;
        base = rd_cnt;
        expect_run(8'd2, 8'd3, 2, 1'b1);
        pulse_start(8'd2, 8'd3);
        wait_count("loop_second_visit", base + 4, 1'b1);
        loop_en = 1'b0;
        wait_idle("loop_idle");

        // Stop while waiting on byte k=1.
        fixed_busy = 8;
        base = tx_cnt;
        push_ev(0, 8'd40);
        push_ev(1, ram[40][7:0]);
        push_ev(1, ram[40][15:8]);
        pulse_start(8'd40, 8'd42);
        wait_count("stop_second_byte", base + 2, 1'b0);
        repeat (2) cyc();
        chk("stop_during_tx_active", {31'd0, tx_active}, 32'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_still_busy", {31'd0, busy}, 32'd1);
        begin
            int n = 0;
            while (busy && n < 100) begin
                cyc();
                n++;
            end
        end
        chk("stop_idle_after_uart", {31'd0, tx_active}, 32'd0);
        wait_idle("stop_idle");
        fixed_busy = 0;

        // Start while busy is ignored.
        expect_run(8'd10, 8'd12, 1, 1'b1);
        base = rd_cnt;
        pulse_start(8'd10, 8'd12);
        wait_count("busy_first_read", base + 1, 1'b1);
        saved = cur_addr;
        pulse_start(8'd99, 8'd99);
        chk("busy_start_cur_addr", {24'd0, cur_addr}, {24'd0, saved});
        wait_idle("busy_start_idle");

        // Start together with stop in IDLE.
        saved = cur_addr;
        first_addr = 8'd50;
        last_addr  = 8'd50;
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", {31'd0, busy}, 32'd0);
        repeat (5) cyc();
        chk("start_stop_still_idle", {31'd0, busy}, 32'd0);
        chk("start_stop_cur_addr", {24'd0, cur_addr}, {24'd0, saved});

        // Asynchronous reset during DWELL, then a fresh start.
        base = tx_cnt;
        expect_run(8'd20, 8'd20, 1, 1'b1);
        pulse_start(8'd20, 8'd20);
        wait_count("rst_fourth_byte", base + 4, 1'b0);
        wait_active("rst_uart_high", 1'b1);
        wait_active("rst_uart_low", 1'b0);
        cyc();
        chk("rst_in_dwell_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cur_addr", {24'd0, cur_addr}, 32'd0);
        chk("arst_tx_dv", {31'd0, tx_dv}, 32'd0);
        chk("arst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
        expect_run(8'd30, 8'd31, 1, 1'b1);
        pulse_start(8'd30, 8'd31);
        wait_idle("after_reset_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
